lcd_write_sequencer: RTL



---
 rtl/lcd_write_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/lcd_write_sequencer.sv
// HD44780-style write-only bus sequencer: one 9-bit command/data item per start/done handshake,
// with setup, enable-pulse, hold and execution-time dwell.
module lcd_write_sequencer #(
    parameter int unsigned T_SETUP     = 4,
    parameter int unsigned T_EN_HIGH   = 16,
    parameter int unsigned T_HOLD      = 4,
    parameter int unsigned T_EXEC      = 2000,
    parameter int unsigned T_EXEC_LONG = 82000
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [7:0] iDATA,
    input  logic       iRS,
    input  logic       iStart,
    output logic       oDone,
    output logic       oBusy,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS
);

    localparam int unsigned MaxDwell = (T_EXEC_LONG > T_EXEC) ? T_EXEC_LONG : T_EXEC;
    localparam int unsigned CntW     = ($clog2(MaxDwell) > 17) ? $clog2(MaxDwell) : 17;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StEnHi,
        StHold,
        StExec,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              start_prev_q;
    logic              long_q, long_d;
    logic [7:0]        data_q, data_d;
    logic              rs_q, rs_d;
    logic              en_q, busy_q, done_q;
    logic              start;

    assign start = iStart & ~start_prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        long_d  = long_q;
        data_d  = data_q;
        rs_d    = rs_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    data_d  = iDATA;
                    rs_d    = iRS;
                    // Clear Display / Return Home (0x01..0x03) need the long execution wait
                    long_d  = ~iRS & (iDATA[7:2] == 6'd0) & (iDATA[1:0] != 2'd0);
                    cnt_d   = CntW'(T_SETUP - 1);
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    cnt_d   = CntW'(T_EN_HIGH - 1);
                    state_d = StEnHi;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StEnHi: begin
                if (cnt_q == '0) begin
                    cnt_d   = CntW'(T_HOLD - 1);
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    cnt_d   = long_q ? CntW'(T_EXEC_LONG - 1) : CntW'(T_EXEC - 1);
                    state_d = StExec;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StExec: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            start_prev_q <= 1'b0;
            long_q       <= 1'b0;
            data_q       <= 8'h00;
            rs_q         <= 1'b0;
            en_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            start_prev_q <= iStart;
            long_q       <= long_d;
            data_q       <= data_d;
            rs_q         <= rs_d;
            // Outputs decode the next state so they are registered yet aligned with the state
            en_q         <= (state_d == StEnHi);
            busy_q       <= (state_d != StIdle);
            done_q       <= (state_d == StDone);
        end
    end

    assign oDone    = done_q;
    assign oBusy    = busy_q;
    assign LCD_DATA = data_q;
    assign LCD_RS   = rs_q;
    assign LCD_EN   = en_q;
    assign LCD_RW   = 1'b0;

endmodule
